// File: rtl/wfg_wb_arb_pkg.sv
// Shared types and helpers for the waveform-generator Wishbone arbiter.
// Holds the FSM state type, the master limit and the timeout counter width.
package wfg_wb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int MAX_M = 8;

  function automatic int tmo_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/wfg_wb_arbiter_if.sv
// Wishbone bundle around the arbiter: master-side bus and slave-side bus.
// The arbiter is a slave to the masters and a master to the shared slave.
interface wfg_wb_arbiter_if #(
  parameter int BUSW  = 32,
  parameter int NUM_M = 2
);

  logic [NUM_M-1:0]          m_cyc_i;
  logic [NUM_M-1:0]          m_stb_i;
  logic [NUM_M-1:0]          m_we_i;
  logic [NUM_M*BUSW/8-1:0]   m_sel_i;
  logic [NUM_M*BUSW-1:0]     m_adr_i;
  logic [NUM_M*BUSW-1:0]     m_dat_i;
  logic [NUM_M-1:0]          m_ack_o;
  logic [NUM_M-1:0]          m_err_o;
  logic [BUSW-1:0]           m_dat_o;

  logic                      wbs_cyc_o;
  logic                      wbs_stb_o;
  logic                      wbs_we_o;
  logic [BUSW/8-1:0]         wbs_sel_o;
  logic [BUSW-1:0]           wbs_adr_o;
  logic [BUSW-1:0]           wbs_dat_o;
  logic                      wbs_ack_i;
  logic [BUSW-1:0]           wbs_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o
  );

  modport master (
    output wbs_cyc_o, wbs_stb_o, wbs_we_o,
    output wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_ack_i, wbs_dat_i
  );

endinterface

// File: rtl/wfg_rr_pick.sv
// Round-robin picker: first requester at or after ptr, with wrap-around.
// Purely combinational; yields a one-hot grant and its index.
module wfg_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    j   = 0;
    // Walk backwards so the closest requester is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wfg_wb_arbiter.sv
// Round-robin Wishbone arbiter: several masters share one slave port.
// Grant is held for a whole cyc; stalled strobes end in a timeout error.
module wfg_wb_arbiter
  import wfg_wb_arb_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wfg_wb_arbiter_if.slave  mbus,
  wfg_wb_arbiter_if.master sbus,
  output logic [NUM_M-1:0] grant_o,
  output logic             busy_o
);

  localparam int IW = $clog2(NUM_M);
  localparam int SW = BUSW / 8;
  localparam int CW = tmo_width(TIMEOUT);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  if (NUM_M < 2 || NUM_M > MAX_M) begin : g_bad_num_m
    $error("wfg_wb_arbiter: NUM_M out of range");
  end

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NUM_M-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;

  logic             owned;
  logic             g_cyc, g_stb, g_we;
  logic [SW-1:0]    g_sel;
  logic [BUSW-1:0]  g_adr, g_dat;
  logic             raw_stb, tmo_hit, rel;

  wfg_rr_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_pick (
    .req (mbus.m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign owned = (state_q == OWNED);
  assign g_cyc = mbus.m_cyc_i[idx_q];
  assign g_stb = mbus.m_stb_i[idx_q];
  assign g_we  = mbus.m_we_i[idx_q];
  assign g_sel = mbus.m_sel_i[int'(idx_q)*SW +: SW];
  assign g_adr = mbus.m_adr_i[int'(idx_q)*BUSW +: BUSW];
  assign g_dat = mbus.m_dat_i[int'(idx_q)*BUSW +: BUSW];

  assign rel     = owned & ~g_cyc;
  assign raw_stb = owned & g_cyc & g_stb;
  // A late ack in the timeout cycle still completes the transfer.
  assign tmo_hit = raw_stb & (cnt_q == TMO) & ~sbus.wbs_ack_i;

  assign sbus.wbs_cyc_o = owned & g_cyc;
  assign sbus.wbs_stb_o = raw_stb & ~tmo_hit;
  assign sbus.wbs_we_o  = owned & g_we;
  assign sbus.wbs_sel_o = owned ? g_sel : '0;
  assign sbus.wbs_adr_o = owned ? g_adr : '0;
  assign sbus.wbs_dat_o = owned ? g_dat : '0;

  assign mbus.m_ack_o = gnt_q
    & {NUM_M{sbus.wbs_ack_i & sbus.wbs_stb_o}};
  assign mbus.m_err_o = gnt_q & {NUM_M{tmo_hit}};
  assign mbus.m_dat_o = sbus.wbs_dat_i;

  assign grant_o = gnt_q;
  assign busy_o  = owned;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|mbus.m_cyc_i) begin
          state_d = OWNED;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      OWNED: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (idx_q == IW'(NUM_M - 1))
                  ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!sbus.wbs_stb_o || sbus.wbs_ack_i || rel) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wfg_wb_arbiter.sv
// Bench for wfg_wb_arbiter: two masters, a register slave with
// configurable ack latency, and a scoreboard of expected responses.
module tb_wfg_wb_arbiter;

  localparam int BUSW = 32;
  localparam int NM   = 2;
  localparam int TMO  = 8;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [NM-1:0] grant_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  wfg_wb_arbiter_if #(.BUSW(BUSW), .NUM_M(NM)) bus ();

  wfg_wb_arbiter #(
    .BUSW    (BUSW),
    .NUM_M   (NM),
    .TIMEOUT (TMO)
  ) u_dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .mbus     (bus),
    .sbus     (bus),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Register slave; ack comes lat cycles after the registered ack slot.
  logic [31:0] mem [16];
  logic        ack_q;
  int          scnt;
  int          lat;
  bit          ack_en;
  bit          slv_init;

  assign bus.wbs_ack_i = ack_q;
  assign bus.wbs_dat_i = mem[bus.wbs_adr_o[5:2]];

  always @(posedge wb_clk_i) begin
    if (slv_init) begin
      foreach (mem[i]) mem[i] <= '0;
      mem[6] <= 32'h1000;
      mem[7] <= 32'h4000;
      ack_q  <= 1'b0;
      scnt   <= 0;
    end else if (wb_rst_i) begin
      ack_q <= 1'b0;
      scnt  <= 0;
    end else if (bus.wbs_cyc_o && bus.wbs_stb_o && !ack_q) begin
      if (scnt == lat) begin
        ack_q <= ack_en;
        scnt  <= 0;
        if (ack_en && bus.wbs_we_o)
          for (int b = 0; b < 4; b++)
            if (bus.wbs_sel_o[b])
              mem[bus.wbs_adr_o[5:2]][b*8 +: 8] <= bus.wbs_dat_o[b*8 +: 8];
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      ack_q <= 1'b0;
      if (!bus.wbs_stb_o) scnt <= 0;
    end
  end

  typedef struct {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [31:0]   dat;
    bit            chkd;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input bit err, input bit chkd,
                      input logic [31:0] dat);
    exp_t e;
    e.ack  = err ? '0 : NM'(1 << m);
    e.err  = err ? NM'(1 << m) : '0;
    e.dat  = dat;
    e.chkd = chkd;
    sb.push_back(e);
  endtask

  always @(negedge wb_clk_i) begin
    exp_t e;
    if (bus.m_ack_o != '0 || bus.m_err_o != '0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {bus.m_ack_o, bus.m_err_o}, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack", bus.m_ack_o, e.ack);
        chk("sb_err", bus.m_err_o, e.err);
        if (e.chkd) chk("sb_rdata", bus.m_dat_o, e.dat);
      end
    end
  end

  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge wb_clk_i);
  endtask

  task automatic req(input int m, input bit we, input logic [31:0] adr,
                     input logic [31:0] dat);
    bus.m_cyc_i[m]             = 1'b1;
    bus.m_stb_i[m]             = 1'b1;
    bus.m_we_i[m]              = we;
    bus.m_sel_i[m*4 +: 4]      = 4'hF;
    bus.m_adr_i[m*BUSW +: BUSW] = adr;
    bus.m_dat_i[m*BUSW +: BUSW] = dat;
  endtask

  task automatic rel(input int m);
    bus.m_cyc_i[m] = 1'b0;
    bus.m_stb_i[m] = 1'b0;
    bus.m_we_i[m]  = 1'b0;
  endtask

  task automatic wait_resp(input int m, input bit keep);
    int n = 0;
    smp();
    while (!(bus.m_ack_o[m] | bus.m_err_o[m]) && n < 64) begin
      nxt();
      smp();
      n++;
    end
    chk("resp_seen", 64'(n < 64), 1);
    nxt();
    if (keep) begin
      bus.m_stb_i[m] = 1'b0;
    end else begin
      rel(m);
      nxt();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, rise, ackc, errc, acks, errs;
    wb_rst_i    = 1'b1;
    slv_init    = 1'b1;
    ack_en      = 1'b1;
    lat         = 0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    nxt();
    slv_init = 1'b0;
    nxt();
    smp();
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ctrl", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o,
                     bus.wbs_sel_o}, 0);
    chk("rst_adr_dat", {bus.wbs_adr_o, bus.wbs_dat_o}, 0);
    chk("rst_resp", {bus.m_ack_o, bus.m_err_o}, 0);

    // single write then read-back by master 0
    nxt();
    wb_rst_i = 1'b0;
    push(0, 0, 0, 0);
    req(0, 1, 32'h10, 32'h1);
    smp();
    chk("t1_c0_stb", bus.wbs_stb_o, 0);
    nxt();
    smp();
    chk("t1_c1_stb", bus.wbs_stb_o, 1);
    chk("t1_c1_grant", grant_o, 2'b01);
    chk("t1_c1_busy", busy_o, 1);
    chk("t1_c1_adr", bus.wbs_adr_o, 32'h10);
    chk("t1_c1_wdat", bus.wbs_dat_o, 32'h1);
    chk("t1_c1_we_sel", {bus.wbs_we_o, bus.wbs_sel_o}, 5'h1F);
    nxt();
    smp();
    chk("t1_c2_ack", bus.m_ack_o, 2'b01);
    nxt();
    rel(0);
    nxt();
    push(0, 0, 1, 32'h1);
    req(0, 0, 32'h10, 0);
    wait_resp(0, 0);

    // simultaneous requests from reset, then hand-over
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
    push(0, 0, 1, 32'h1000);
    push(1, 0, 1, 32'h4000);
    req(0, 0, 32'h18, 0);
    req(1, 0, 32'h1C, 0);
    nxt();
    smp();
    chk("t2_c1_grant", grant_o, 2'b01);
    nxt();
    smp();
    chk("t2_c2_ack", bus.m_ack_o, 2'b01);
    nxt();
    rel(0);
    smp();
    chk("t2_c3_cyc", bus.wbs_cyc_o, 0);
    nxt();
    smp();
    chk("t2_c4_idle", {busy_o, grant_o}, 0);
    nxt();
    smp();
    chk("t2_c5_grant", grant_o, 2'b10);
    chk("t2_c5_cyc", bus.wbs_cyc_o, 1);
    nxt();
    smp();
    chk("t2_c6_ack", bus.m_ack_o, 2'b10);
    nxt();
    rel(1);
    nxt();
    push(0, 0, 0, 0);
    push(1, 0, 0, 0);
    req(0, 1, 32'h30, 32'hA);
    req(1, 1, 32'h34, 32'hB);
    nxt();
    smp();
    chk("t2_rr_wrap", grant_o, 2'b01);
    wait_resp(0, 0);
    wait_resp(1, 0);

    // master 1 keeps cyc over three reads while master 0 waits
    push(1, 0, 1, 32'h1000);
    req(1, 0, 32'h18, 0);
    wait_resp(1, 1);
    req(0, 0, 32'h10, 0);
    push(1, 0, 1, 32'h4000);
    req(1, 0, 32'h1C, 0);
    wait_resp(1, 1);
    push(1, 0, 1, 32'h0);
    req(1, 0, 32'h20, 0);
    wait_resp(1, 1);
    smp();
    chk("t3_hold", grant_o, 2'b10);
    nxt();
    rel(1);
    push(0, 0, 1, 32'h1);
    wait_resp(0, 0);

    // slave never acks
    ack_en = 1'b0;
    push(0, 1, 0, 0);
    req(0, 0, 32'h24, 0);
    c = 0; rise = -1; errc = -1; acks = 0;
    while (errc < 0 && c < 40) begin
      nxt();
      c++;
      smp();
      if (rise < 0 && bus.wbs_stb_o) rise = c;
      if (bus.m_ack_o != '0) acks++;
      if (bus.m_err_o[0]) errc = c;
    end
    chk("t4_rise", rise, 1);
    chk("t4_err_lat", errc - rise, TMO);
    chk("t4_stb_forced", bus.wbs_stb_o, 0);
    chk("t4_no_ack", acks, 0);
    nxt();
    rel(0);
    nxt();

    // ack lands in the timeout cycle, then a stalled strobe follows
    ack_en = 1'b1;
    lat    = TMO - 1;
    push(0, 0, 1, 32'h1000);
    push(0, 1, 0, 0);
    req(0, 0, 32'h18, 0);
    c = 0; ackc = -1; errs = 0;
    while (ackc < 0 && c < 40) begin
      nxt();
      c++;
      smp();
      if (bus.m_err_o != '0) errs++;
      if (bus.m_ack_o[0]) ackc = c;
    end
    chk("t5_ack_lat", ackc, TMO + 1);
    chk("t5_no_err", errs, 0);
    nxt();
    c++;
    ack_en = 1'b0;
    bus.m_adr_i[31:0] = 32'h1C;
    errc = -1;
    smp();
    if (bus.m_err_o[0]) errc = c;
    while (errc < 0 && c < 80) begin
      nxt();
      c++;
      smp();
      if (bus.m_err_o[0]) errc = c;
    end
    chk("t5_cnt_cleared", errc - ackc, TMO + 1);
    nxt();
    rel(0);
    nxt();

    // reset in the middle of a transfer
    ack_en = 1'b1;
    lat    = 3;
    req(0, 1, 32'h28, 32'h55);
    nxt();
    smp();
    chk("t6_stb", bus.wbs_stb_o, 1);
    nxt();
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
    rel(0);
    smp();
    chk("t6_grant", {busy_o, grant_o}, 0);
    chk("t6_ctrl", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o,
                    bus.wbs_sel_o}, 0);
    chk("t6_adr_dat", {bus.wbs_adr_o, bus.wbs_dat_o}, 0);
    chk("t6_resp", {bus.m_ack_o, bus.m_err_o}, 0);
    nxt();
    lat = 0;
    push(1, 0, 0, 0);
    req(1, 1, 32'h2C, 32'h77);
    nxt();
    smp();
    chk("t6_m1_grant", grant_o, 2'b10);
    wait_resp(1, 0);
    push(1, 0, 1, 32'h0);
    req(1, 0, 32'h28, 0);
    wait_resp(1, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
